// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and BCD correction constants
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DIG_MAX = 9;
  localparam int ADJ_THR = 8;
  localparam int ADJ_SUB = 3;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble nibble correction after a right shift
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] in,
  output logic [3:0] out
);
  assign out = in >= 4'(ADJ_THR) ? in - 4'(ADJ_SUB) : in;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD to binary converter using shift-right and subtract-3
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [4*NDIG-1:0] BCD,
  output logic [BW-1:0]     Bin,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);
  localparam int SW = 4*NDIG + BW;
  localparam int CW = BW > 1 ? $clog2(BW) : 1;
  state_t          state, state_nx;
  logic [SW-1:0]   s, s_sh, s_adj;
  logic [CW-1:0]   count;
  logic [NDIG-1:0] bad;
  logic            last, load;
  assign s_sh = s >> 1;
  assign s_adj[BW-1:0] = s_sh[BW-1:0];
  genvar d;
  for (d = 0; d < NDIG; d++) begin : g_dig
    bcd_digit_adj u_adj (.in(s_sh[BW+4*d +: 4]), .out(s_adj[BW+4*d +: 4]));
    assign bad[d] = BCD[4*d +: 4] > 4'(DIG_MAX);
  end
  assign last = count == CW'(BW-1);
  assign load = state == IDLE && Start;
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  // state register
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state <= IDLE;
    else state <= state_nx;
  // next state: invalid digits skip straight to DONE; DONE always falls back to IDLE
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = Start ? (|bad ? DONE : CALC) : IDLE;
    else if (state == CALC) state_nx = last ? DONE : CALC;
  end
  // shift register, step counter and result registers, updated only on DONE entry
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      s     <= '0;
      count <= '0;
      Bin   <= '0;
      Err   <= 1'b0;
    end else if (load) begin
      s     <= {BCD, {BW{1'b0}}};
      count <= '0;
      if (|bad) begin
        Bin <= '0;
        Err <= 1'b1;
      end
    end else if (state == CALC) begin
      s     <= s_adj;
      count <= last ? '0 : count + 1'b1;
      if (last) begin
        Bin <= s_adj[BW-1:0];
        Err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: vector table, random and corner-sequence checks against a decimal model
module tb_bcd_to_bin_seq;
  logic        Clock = 1'b0, Resetn = 1'b1, Start = 1'b0;
  logic [11:0] BCD = '0;
  logic [9:0]  Bin;
  logic        Done, Busy, Err;
  int tests = 0, fails = 0;

  bcd_to_bin_seq #(.NDIG(3), .BW(10)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .BCD(BCD),
    .Bin(Bin), .Done(Done), .Busy(Busy), .Err(Err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [11:0] bcd;
    int          bin;
    bit          err;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // reference: decimal value of the digits, error if any digit is not a decimal digit
  task automatic model(input logic [11:0] b, output int val, output bit err);
    int n;
    val = 0;
    err = 0;
    for (int i = 2; i >= 0; i--) begin
      n = int'((b >> (4 * i)) & 12'hF);
      if (n > 9) err = 1;
      val = val * 10 + n;
    end
    if (err) val = 0;
  endtask

  task automatic conv(input string nm, input logic [11:0] b, input int eb, input bit ee, input int el);
    int  lat = 0;
    bit  seen = 0;
    @(negedge Clock);
    Start = 1'b1;
    BCD   = b;
    @(posedge Clock);
    #1 Start = 1'b0;
    BCD = 12'($urandom);
    while (!seen && lat < 40) begin
      @(negedge Clock);
      lat++;
      if (lat == 1) check({nm, " busy"}, int'(Busy), 1);
      if (Done) seen = 1;
    end
    check({nm, " latency"}, lat, el);
    check({nm, " bin"}, int'(Bin), eb);
    check({nm, " err"}, int'(Err), int'(ee));
    @(negedge Clock);
    check({nm, " done_pulse"}, int'(Done), 0);
    check({nm, " bin_hold"}, int'(Bin), eb);
  endtask

  initial begin
    vec_t tbl[8];
    int   val, dones, k, lat;
    bit   err, ok;
    logic [11:0] b;
    tbl[0] = '{12'h999, 999, 1'b0, 11};
    tbl[1] = '{12'h000, 0,   1'b0, 11};
    tbl[2] = '{12'h255, 255, 1'b0, 11};
    tbl[3] = '{12'h1A3, 0,   1'b1, 1};
    tbl[4] = '{12'h001, 1,   1'b0, 11};
    tbl[5] = '{12'h512, 512, 1'b0, 11};
    tbl[6] = '{12'hF09, 0,   1'b1, 1};
    tbl[7] = '{12'h90C, 0,   1'b1, 1};

    #2 Resetn = 1'b0;
    #2;
    check("rst bin", int'(Bin), 0);
    check("rst err", int'(Err), 0);
    check("rst done", int'(Done), 0);
    check("rst busy", int'(Busy), 0);
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;

    foreach (tbl[i]) conv($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].bin, tbl[i].err, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      b = (i % 4 == 0) ? 12'($urandom) : to_bcd(int'($urandom_range(0, 999)));
      model(b, val, err);
      conv($sformatf("rnd%0d_%03h", i, b), b, val, err, err ? 1 : 11);
    end

    // second Start during CALC must be dropped
    @(negedge Clock);
    Start = 1'b1;
    BCD   = 12'h456;
    @(posedge Clock);
    #1 Start = 1'b0;
    dones = 0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clock);
      if (c == 3) begin
        Start = 1'b1;
        BCD   = 12'h123;
      end
      if (c == 4) Start = 1'b0;
      if (Done) begin
        dones++;
        if (lat == 0) lat = c;
        check("drop bin", int'(Bin), 456);
      end
    end
    check("drop dones", dones, 1);
    check("drop latency", lat, 11);

    // mid-CALC reset aborts with no Done
    conv("pre_rst", 12'hB00, 0, 1'b1, 1);
    @(negedge Clock);
    Start = 1'b1;
    BCD   = 12'h321;
    @(posedge Clock);
    #1 Start = 1'b0;
    repeat (5) @(negedge Clock);
    #1 Resetn = 1'b0;
    #1;
    check("abort bin", int'(Bin), 0);
    check("abort err", int'(Err), 0);
    check("abort busy", int'(Busy), 0);
    check("abort done", int'(Done), 0);
    dones = 0;
    repeat (3) begin
      @(negedge Clock);
      dones += int'(Done);
    end
    Resetn = 1'b1;
    repeat (12) begin
      @(negedge Clock);
      dones += int'(Done);
    end
    check("abort dones", dones, 0);
    conv("post_rst", 12'h789, 789, 1'b0, 11);

    // Start held high: one result every 12 cycles across 000..999
    @(negedge Clock);
    Start = 1'b1;
    BCD   = to_bcd(0);
    for (int v = 0; v < 1000; v++) begin
      k = 0;
      ok = 0;
      while (!ok && k < 20) begin
        @(negedge Clock);
        k++;
        ok = Done;
      end
      check($sformatf("held v%0d period", v), k, v == 0 ? 11 : 12);
      check($sformatf("held v%0d bin", v), int'(Bin), v);
      BCD = to_bcd(v + 1 > 999 ? 0 : v + 1);
      if (v == 999) Start = 1'b0;
    end
    @(negedge Clock);
    @(negedge Clock);
    check("held idle", int'(Busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 The block SHALL have parameter NDIG, default 3, giving the number of BCD input digits (legal 1..4).
REQ-002 The block SHALL have parameter BW, default 10, giving the binary output width; BW SHALL satisfy 2^BW >= 10^NDIG.
REQ-003 The block SHALL have port Clock, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port Resetn, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit, a conversion request sampled only in IDLE.
REQ-006 The block SHALL have port BCD, input, 4*NDIG bits, packed digits with the most significant digit in the top nibble, sampled with Start.
REQ-007 The block SHALL have port Bin, output, BW bits, the binary result, held until the next completion.
REQ-008 The block SHALL have port Done, output, 1 bit, a one-cycle pulse marking Bin/Err valid.
REQ-009 The block SHALL have port Busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 The block SHALL have port Err, output, 1 bit, set when any sampled digit exceeds 9, held with Bin.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
REQ-012 In IDLE with Start=1 and all digits <=9, the block SHALL load shift register S = {BCD, BW'b0} and count=0 at that edge and go to CALC.
REQ-013 In IDLE with Start=1 and any digit >9, the block SHALL go directly to DONE and load Bin=0 and Err=1 at that edge.
REQ-014 Each CALC edge SHALL shift S right by 1 bit, then subtract 3 from every BCD nibble of the shifted value that is >=8, and increment count.
REQ-015 On the CALC edge where count==BW-1, the block SHALL load Bin with the low BW bits of the updated S, set Err=0, and go to DONE.
REQ-016 Done SHALL be 1 exactly in the DONE state; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-017 Latency: a valid conversion SHALL assert Done in the (BW+1)th cycle after the Start edge (11 for defaults); an invalid one SHALL assert Done in the 1st cycle.
REQ-018 Start SHALL be ignored in CALC and DONE, and BCD changes outside the Start edge SHALL have no effect.
REQ-019 With Start held at 1, the block SHALL begin a new conversion on the IDLE edge following DONE, giving one result every BW+2 cycles.
REQ-020 Bin and Err SHALL change only on the DONE-entry edge and SHALL be stable at all other times.
REQ-021 Count width SHALL be ceil(log2(BW)) bits, and count SHALL never wrap within a conversion.

Reset
REQ-022 Resetn=0 SHALL force, asynchronously, state=IDLE, count=0, S=0, Bin=0, Err=0, Done=0 and Busy=0.
REQ-023 Reset asserted mid-CALC SHALL abort the conversion with no Done pulse, and the first Start after release SHALL convert normally.

Structure
REQ-024 Package bcd_pkg SHALL hold the state typedef (IDLE/CALC/DONE), the digit maximum constant 9 and the correction constants (threshold 8, subtrahend 3).
REQ-025 A sub-module bcd_digit_adj SHALL implement the per-nibble rule (in >= 8 ? in - 3 : in), with NDIG instances.

Verification
REQ-026 Reset, then BCD=12'h999 with Start=1 for one cycle -> Busy=1, Done=1 in the 11th cycle, Bin=10'd999 (0x3E7), Err=0.
REQ-027 BCD=12'h000 -> Bin=0 and Err=0 after 11 cycles; BCD=12'h255 -> Bin=10'd255.
REQ-028 BCD=12'h1A3 -> Done in the 1st cycle, Err=1, Bin=0, no CALC cycles.
REQ-029 Start pulsed again with BCD=12'h123 during CALC of 12'h456 -> single Done, Bin=456; the second request is dropped.
REQ-030 Resetn pulsed low at cycle 5 of a conversion -> all outputs 0 immediately, no Done, and the next conversion of 12'h789 gives Bin=789.
REQ-031 Start held high, BCD stepping through 000..999 -> Done every 12 cycles, and every Bin matches the decimal value.
